// File: rtl/seq_gen_1011_if.sv
// Serial pattern transmitter bus: transfer request fields and serial output stream.
interface seq_gen_1011_if #(
   parameter int unsigned CNT_W = 4
) ();
   logic             start;
   logic [CNT_W-1:0] rep;
   logic [CNT_W-1:0] gap;
   logic             dout;
   logic             valid;
   logic             busy;
   logic             frame_end;
   logic             done;

   // Requester side: drives the request, observes the stream
   modport master (
      output start, rep, gap,
      input  dout, valid, busy, frame_end, done
   );

   // Transmitter side: accepts the request, drives the stream
   modport slave (
      input  start, rep, gap,
      output dout, valid, busy, frame_end, done
   );
endinterface

// File: rtl/seq_gen_1011.sv
// Framed serial transmitter: sends PATTERN (MSB first) rep times, with gap zero bits
// between frames and none after the last, then pulses done for one cycle.
module seq_gen_1011 #(
   parameter int unsigned        PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int unsigned        CNT_W   = 4
) (
   input logic           clk,
   input logic           res,
   seq_gen_1011_if.slave bus
);

   localparam int unsigned IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

   typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_t;

   state_t           r_state, w_state_next;
   logic [IDX_W-1:0] r_bit_idx, w_bit_idx_next;
   logic [CNT_W-1:0] r_frm_cnt, w_frm_cnt_next;
   logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_next;
   logic [CNT_W-1:0] r_rep_q, w_rep_next;
   logic [CNT_W-1:0] r_gap_q, w_gap_next;
   logic [CNT_W-1:0] w_rep_m1, w_gap_m1;
   logic             w_dout, w_valid, w_busy, w_frame_end, w_done;

   // Only compared in SEND/GAP, where the latched values are known to be nonzero
   assign w_rep_m1 = r_rep_q - CNT_W'(1);
   assign w_gap_m1 = r_gap_q - CNT_W'(1);

   // State and counter registers with synchronous reset taking priority
   always_ff @(posedge clk) begin
      if (res) begin
         r_state   <= StIdle;
         r_bit_idx <= '0;
         r_frm_cnt <= '0;
         r_gap_cnt <= '0;
         r_rep_q   <= '0;
         r_gap_q   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_bit_idx <= w_bit_idx_next;
         r_frm_cnt <= w_frm_cnt_next;
         r_gap_cnt <= w_gap_cnt_next;
         r_rep_q   <= w_rep_next;
         r_gap_q   <= w_gap_next;
      end
   end

   // Next-state logic and Moore output decode from state and counters
   always_comb begin
      w_state_next   = r_state;
      w_bit_idx_next = r_bit_idx;
      w_frm_cnt_next = r_frm_cnt;
      w_gap_cnt_next = r_gap_cnt;
      w_rep_next     = r_rep_q;
      w_gap_next     = r_gap_q;
      w_dout         = 1'b0;
      w_valid        = 1'b0;
      w_busy         = 1'b0;
      w_frame_end    = 1'b0;
      w_done         = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_rep_next     = bus.rep;
               w_gap_next     = bus.gap;
               w_bit_idx_next = '0;
               w_frm_cnt_next = '0;
               w_gap_cnt_next = '0;
               // An empty transfer still reports completion
               w_state_next   = (bus.rep != '0) ? StSend : StDone;
            end
         end
         StSend: begin
            w_dout  = PATTERN[LAST_IDX - r_bit_idx];
            w_valid = 1'b1;
            w_busy  = 1'b1;
            if (r_bit_idx == LAST_IDX) begin
               w_frame_end    = 1'b1;
               w_bit_idx_next = '0;
               w_frm_cnt_next = r_frm_cnt + CNT_W'(1);
               if (r_frm_cnt == w_rep_m1) begin
                  w_state_next = StDone;
               end else if (r_gap_q == '0) begin
                  w_state_next = StSend;
               end else begin
                  w_state_next = StGap;
               end
            end else begin
               w_bit_idx_next = r_bit_idx + IDX_W'(1);
            end
         end
         StGap: begin
            w_valid = 1'b1;
            w_busy  = 1'b1;
            if (r_gap_cnt == w_gap_m1) begin
               w_gap_cnt_next = '0;
               w_state_next   = StSend;
            end else begin
               w_gap_cnt_next = r_gap_cnt + CNT_W'(1);
            end
         end
         StDone: begin
            w_done       = 1'b1;
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   assign bus.dout      = w_dout;
   assign bus.valid     = w_valid;
   assign bus.busy      = w_busy;
   assign bus.frame_end = w_frame_end;
   assign bus.done      = w_done;

endmodule

// File: tb/tb_seq_gen_1011.sv
// Bench for seq_gen_1011: vector table, hand-written corner sequences and random
// stimulus against a queue-based model of the expected output stream.
module tb_seq_gen_1011;

   logic clk;
   logic res;
   int   n_checks;
   int   n_errors;

   seq_gen_1011_if #(.CNT_W(4)) bus ();

   seq_gen_1011 #(
      .PAT_LEN (4),
      .PATTERN (4'b1011),
      .CNT_W   (4)
   ) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs packed as {dout, valid, busy, frame_end, done}
   logic [4:0] act;
   logic [4:0] exp_q[$];
   logic [3:0] pat;

   typedef struct {
      logic       s;
      logic [3:0] rep;
      logic [3:0] gap;
      logic       rs;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [4:0] got, input logic [4:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %b required %b (dout,valid,busy,frame_end,done) at %0t",
                  name, got, want, $time);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, got, want, $time);
      end
   endtask

   // Expected cycles of one accepted transfer: frames, inter-frame gaps, then done
   task automatic push_xfer(input int r, input int g);
      for (int f = 0; f < r; f++) begin
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back({pat[3-b], 1'b1, 1'b1, (b == 3), 1'b0});
         end
         if (f != r - 1) begin
            for (int k = 0; k < g; k++) exp_q.push_back(5'b01100);
         end
      end
      exp_q.push_back(5'b00001);
   endtask

   // One clock: drive inputs, advance model at the edge, sample on the falling edge
   task automatic cycle(input logic s, input logic [3:0] r, input logic [3:0] g,
                        input logic rs);
      logic [4:0] want;
      bus.start = s;
      bus.rep   = r;
      bus.gap   = g;
      res       = rs;
      @(posedge clk);
      if (rs) begin
         exp_q.delete();
      end else if (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
      end else if (s) begin
         push_xfer(int'(r), int'(g));
      end
      @(negedge clk);
      act  = {bus.dout, bus.valid, bus.busy, bus.frame_end, bus.done};
      want = (exp_q.size() != 0) ? exp_q[0] : 5'b00000;
      chk("model", act, want);
   endtask

   initial begin
      int         nv, nfe, ndone, nb, hits;
      logic [15:0] strm;
      logic [3:0] hist;
      logic       s;
      logic [3:0] r, g;
      logic       rs;

      n_checks  = 0;
      n_errors  = 0;
      pat       = 4'b1011;
      res       = 1'b1;
      bus.start = 1'b0;
      bus.rep   = '0;
      bus.gap   = '0;

      vecs[0]  = '{1'b1, 4'd1, 4'd3, 1'b0, 5'b11100};
      vecs[1]  = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b01100};
      vecs[2]  = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b11100};
      vecs[3]  = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b11110};
      vecs[4]  = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b00001};
      vecs[5]  = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b00000};
      vecs[6]  = '{1'b1, 4'd0, 4'd5, 1'b0, 5'b00001};
      vecs[7]  = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b00000};
      vecs[8]  = '{1'b1, 4'd2, 4'd0, 1'b0, 5'b11100};
      vecs[9]  = '{1'b0, 4'd9, 4'd9, 1'b0, 5'b01100};
      vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b11100};
      vecs[11] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b11110};
      vecs[12] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b11100};
      vecs[13] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b01100};
      vecs[14] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b11100};
      vecs[15] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b11110};
      vecs[16] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b00001};
      vecs[17] = '{1'b0, 4'd0, 4'd0, 1'b0, 5'b00000};

      // Reset held for two cycles with start high, then idle with start low
      cycle(1'b1, 4'd3, 4'd1, 1'b1);
      chk("reset_0", act, 5'b00000);
      cycle(1'b1, 4'd3, 4'd1, 1'b1);
      chk("reset_1", act, 5'b00000);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 4'd3, 4'd1, 1'b0);
         chk($sformatf("post_reset_idle_%0d", i), act, 5'b00000);
      end

      // Single frame, empty transfer, back-to-back frames
      for (int i = 0; i < 18; i++) begin
         cycle(vecs[i].s, vecs[i].rep, vecs[i].gap, vecs[i].rs);
         chk($sformatf("vec_%0d", i), act, vecs[i].exp);
      end

      // Multi-frame with gap: 1011 00 1011 00 1011
      nv = 0; nfe = 0; ndone = 0; strm = '0;
      cycle(1'b1, 4'd3, 4'd2, 1'b0);
      for (int i = 0; i < 24; i++) begin
         if (i != 0) cycle(1'b0, 4'd0, 4'd0, 1'b0);
         if (act[3]) begin
            nv++;
            strm = {strm[14:0], act[4]};
         end
         if (act[1]) nfe++;
         if (act[0]) ndone++;
      end
      chk_int("multi_valid_cycles", nv, 16);
      chk_int("multi_stream", int'(strm), 16'hB2CB);
      chk_int("multi_frame_end", nfe, 3);
      chk_int("multi_done", ndone, 1);

      // Start held through a rep=2, gap=1 transfer
      nb = 0; nv = 0; ndone = 0; strm = '0;
      for (int i = 0; i < 30 && ndone == 0; i++) begin
         cycle(1'b1, 4'd2, 4'd1, 1'b0);
         if (act[2]) nb++;
         if (act[3]) begin
            nv++;
            strm = {strm[14:0], act[4]};
         end
         if (act[0]) ndone++;
      end
      chk_int("held_busy", nb, 9);
      chk_int("held_done", ndone, 1);
      chk_int("held_stream", int'(strm[8:0]), 9'h16B);
      cycle(1'b1, 4'd2, 4'd1, 1'b0);
      chk("held_idle", act, 5'b00000);
      cycle(1'b1, 4'd2, 4'd1, 1'b0);
      chk("held_restart", act, 5'b11100);
      for (int i = 0; i < 12; i++) cycle(1'b0, 4'd0, 4'd0, 1'b0);

      // Reset in the second bit of a frame aborts with no done
      cycle(1'b1, 4'd3, 4'd1, 1'b0);
      cycle(1'b0, 4'd3, 4'd1, 1'b0);
      chk("abort_bit1", act, 5'b01100);
      cycle(1'b0, 4'd3, 4'd1, 1'b1);
      chk("abort_reset", act, 5'b00000);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 4'd3, 4'd1, 1'b0);
         if (act[0]) ndone++;
      end
      chk_int("abort_no_done", ndone, 0);

      // Maximum frame count
      nb = 0; ndone = 0;
      cycle(1'b1, 4'd15, 4'd0, 1'b0);
      if (act[2]) nb++;
      for (int i = 0; i < 64; i++) begin
         cycle(1'b0, 4'd0, 4'd0, 1'b0);
         if (act[2]) nb++;
         if (act[0]) ndone++;
      end
      chk_int("max_rep_busy", nb, 60);
      chk_int("max_rep_done", ndone, 1);

      // Loopback into a non-overlapping 1011 detector
      hits = 0; hist = '0;
      cycle(1'b1, 4'd4, 4'd1, 1'b0);
      for (int i = 0; i < 30; i++) begin
         if (i != 0) cycle(1'b0, 4'd0, 4'd0, 1'b0);
         hist = {hist[2:0], act[4]};
         if (hist == 4'b1011) begin
            hits++;
            hist = '0;
         end
      end
      chk_int("loopback_hits", hits, 4);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         s  = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
         g  = 4'($urandom_range(0, 3));
         rs = ($urandom_range(0, 99) == 0);
         cycle(s, r, g, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_gen_1011.md
# seq_gen_1011

Serial pattern transmitter that emits the 4-bit sequence 1011, MSB first, as a framed bit stream. It is the stimulus/transmit side of the 1011 sequence-detection path. On a start request it sends a programmable number of frames, separated by a programmable number of zero gap bits, and then signals completion. Its output drives a serial single-bit detector input directly.

## Interface
- PATTERN, 4'b1011, frame bit pattern, transmitted MSB first
- PAT_LEN, 4, frame length in bits; must equal the width of PATTERN
- CNT_W, 4, width of the frame-count and gap-count fields
- clk  in  1  rising-edge clock; the block's single clock
- res  in  1  reset; synchronous, active-high
- start  in  1  transfer request; sampled only in IDLE
- rep  in  CNT_W  number of frames to send; latched at start
- gap  in  CNT_W  number of zero bits between frames; latched at start
- dout  out  1  serial data bit
- valid  out  1  dout carries a transmitted bit (frame or gap)
- busy  out  1  transfer in progress
- frame_end  out  1  high on the last bit of each frame
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SEND, GAP, DONE. All outputs are Moore outputs, decoded only from the state register and the counters, never from inputs.
- Internal registers:
  - bit_idx, 0..PAT_LEN-1
  - frm_cnt, CNT_W bits
  - gap_cnt, CNT_W bits
  - rep_q and gap_q, latched copies of rep and gap
- IDLE:
  - Outputs: dout=0, valid=0, busy=0, frame_end=0, done=0.
  - start=1 latches rep_q and gap_q and clears bit_idx, frm_cnt and gap_cnt.
  - Next state is SEND if rep≠0, or DONE if rep=0. An empty transfer still produces a done pulse.
- SEND:
  - Outputs: dout=PATTERN[PAT_LEN-1-bit_idx], valid=1, busy=1.
  - frame_end=1 when bit_idx=PAT_LEN-1.
  - bit_idx increments every cycle.
  - On the last bit, bit_idx wraps to 0, frm_cnt increments, and the next state is chosen as follows:
    - DONE if frm_cnt=rep_q-1.
    - Otherwise SEND if gap_q=0 (back-to-back frames).
    - Otherwise GAP.
- GAP:
  - Outputs: dout=0, valid=1, busy=1.
  - gap_cnt increments each cycle.
  - When gap_cnt=gap_q-1, gap_cnt clears and the next state is SEND.
- DONE:
  - Outputs: done=1, busy=0, valid=0, dout=0.
  - Next state is IDLE unconditionally.
- start outside IDLE (SEND, GAP, DONE) is ignored. It is not queued.
- Changes to rep and gap after the start cycle have no effect on the transfer in progress.
- Counter arithmetic is unsigned at CNT_W bits. rep=2^CNT_W-1 (15 by default) is the maximum frame count. No wrap occurs, because the comparisons run against rep_q-1 and gap_q-1 only when those are ≥0.

## Timing
- Reset values: state=IDLE, all counters 0, dout=0, valid=0, busy=0, frame_end=0, done=0. Outputs reach these values in the cycle after the res edge.
- res=1 has priority over every state and over start. Reset mid-transfer aborts immediately: the next cycle is IDLE with no done pulse.
- Latency: start is sampled at edge k. The first frame bit is on dout with valid=1 from edge k to edge k+1.
- Transfer length with rep≥1: rep·PAT_LEN + (rep-1)·gap cycles with busy=1.
- done is high for exactly the one cycle after the last frame bit.
- No gap bits follow the last frame.
- A new start is accepted no earlier than the cycle after done, when the block is back in IDLE.
- Minimum spacing: rep=0 gives done one cycle after start, and IDLE the cycle after that.

## Test plan
- Reset: assert res for 2 cycles with start=1 held -> all outputs 0 throughout. After release with start=0, the block stays in IDLE.
- Single frame: rep=1, gap=3, start pulse -> dout=1,0,1,1 with valid=1 over 4 cycles, frame_end in cycle 4, done in cycle 5, busy=1 for exactly 4 cycles.
- Multi-frame with gap: rep=3, gap=2 -> dout stream 1011 00 1011 00 1011 (16 valid cycles), 3 frame_end pulses, 1 done.
- Back-to-back and empty: rep=2, gap=0 -> 10111011 over 8 cycles, then done. rep=0 -> done the cycle after start, valid never high.
- Abuse: start held high through an entire rep=2, gap=1 transfer -> exactly one transfer of 9 bits, then a second transfer begins the cycle after IDLE is re-entered. Assert res in cycle 2 of a frame -> outputs 0 the next cycle, no done.
- Loopback: dout drives a 1011 non-overlapping Moore detector model, rep=4, gap=1 -> exactly 4 detector hits, one per frame.
